// File: rtl/crop_pkg.sv
// crop_pkg: shared FSM type and geometry helpers for image_crop_stream.
// Related build macro: CROP_TLAST_EN (handled in the interface and top files).
package crop_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Counter width for a 0..n-1 range; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int row_w(input int in_rows);
    return cnt_w(in_rows);
  endfunction

  function automatic int col_w(input int in_cols);
    return cnt_w(in_cols);
  endfunction

  // True when pos lies inside [first, first+len-1].
  function automatic logic in_span(input int pos, input int first, input int len);
    return (pos >= first) && (pos < first + len);
  endfunction

endpackage

// File: rtl/image_crop_stream_if.sv
// image_crop_stream_if: one AXI-stream pixel channel (TDATA/TVALID/TREADY).
// With CROP_TLAST_EN defined the channel also carries TLAST.
interface image_crop_stream_if #(
  parameter int WIDTH = 16
) ();

  logic [WIDTH-1:0] TDATA;
  logic             TVALID;
  logic             TREADY;
`ifdef CROP_TLAST_EN
  logic             TLAST;

  modport master (output TDATA, TVALID, TLAST, input TREADY);
  modport slave  (input TDATA, TVALID, TLAST, output TREADY);
`else
  modport master (output TDATA, TVALID, input TREADY);
  modport slave  (input TDATA, TVALID, output TREADY);
`endif

endinterface

// File: rtl/axis_reg_slice.sv
// axis_reg_slice: single-entry AXI-stream output register. The owner decides when
// to load (it only loads when the slot is empty or being emptied this cycle).
// An optional TLAST bit is carried as the top payload bit by the instantiating module.
module axis_reg_slice #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  // Capture a new beat on load; drop valid when the held beat leaves with no replacement.
  // NOTE: registers use <= so every flop samples pre-edge values, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      // NOTE: this single data register is reset so the bus reads 0 after reset; a deep
      // storage array would normally be left unreset.
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/image_crop_stream.sv
// image_crop_stream: forwards the OUT_ROWS x OUT_COLS window at (Y_1, X_1) of a raster
// IN_ROWS x IN_COLS pixel stream, one frame per ap_start. Pixels are passed bit-exact.
// Build macro CROP_TLAST_EN adds crop_out TLAST on the final crop pixel.
module image_crop_stream
  import crop_pkg::*;
#(
  parameter int FP_TOTAL = 16,
  parameter int IN_ROWS  = 100,
  parameter int IN_COLS  = 160,
  parameter int OUT_ROWS = 48,
  parameter int OUT_COLS = 48,
  parameter int Y_1      = 10,
  parameter int X_1      = 10
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  input  logic                       ap_start,
  output logic                       ap_done,
  output logic                       ap_idle,
  output logic                       ap_ready,
  image_crop_stream_if.slave         img_in_V_data_0_V,
  image_crop_stream_if.master        crop_out_V_data_0_V
);

  localparam int ROW_W = row_w(IN_ROWS);
  localparam int COL_W = col_w(IN_COLS);
`ifdef CROP_TLAST_EN
  localparam int PAY_W = FP_TOTAL + 1;
`else
  localparam int PAY_W = FP_TOTAL;
`endif

  if (Y_1 + OUT_ROWS > IN_ROWS) begin : g_bad_rows
    $error("image_crop_stream: Y_1 + OUT_ROWS exceeds IN_ROWS");
  end
  if (X_1 + OUT_COLS > IN_COLS) begin : g_bad_cols
    $error("image_crop_stream: X_1 + OUT_COLS exceeds IN_COLS");
  end

  state_t             state, state_nx;
  logic [ROW_W-1:0]   row;
  logic [COL_W-1:0]   col;
  logic               in_win, last_row, last_col, in_fire, frame_end, load;
  logic               out_valid, out_ready;
  logic [PAY_W-1:0]   pay_in, pay_out;

  assign in_win    = in_span(int'(row), Y_1, OUT_ROWS) && in_span(int'(col), X_1, OUT_COLS);
  assign last_row  = (row == ROW_W'(IN_ROWS - 1));
  assign last_col  = (col == COL_W'(IN_COLS - 1));
  assign out_ready = crop_out_V_data_0_V.TREADY;

  // Out-of-window pixels are always accepted (and dropped); in-window ones wait for the slot.
  assign img_in_V_data_0_V.TREADY = (state == RUN) && (!in_win || !out_valid || out_ready);
  assign in_fire   = img_in_V_data_0_V.TVALID && img_in_V_data_0_V.TREADY;
  assign frame_end = in_fire && last_row && last_col;
  assign load      = in_fire && in_win;

`ifdef CROP_TLAST_EN
  assign pay_in = {in_win && (row == ROW_W'(Y_1 + OUT_ROWS - 1)) && (col == COL_W'(X_1 + OUT_COLS - 1)),
                   img_in_V_data_0_V.TDATA};
  assign crop_out_V_data_0_V.TDATA = pay_out[FP_TOTAL-1:0];
  assign crop_out_V_data_0_V.TLAST = pay_out[FP_TOTAL];
`else
  assign pay_in = img_in_V_data_0_V.TDATA;
  assign crop_out_V_data_0_V.TDATA = pay_out;
`endif
  assign crop_out_V_data_0_V.TVALID = out_valid;

  assign ap_idle  = (state == IDLE);
  assign ap_done  = (state == DONE);
  assign ap_ready = (state == DONE);

  // Raster position of the next input pixel; wraps to (0,0) after the last pixel of a frame.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      row <= '0;
      col <= '0;
    end else if (in_fire) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Frame control state register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= IDLE;
    else           state <= state_nx;
  end

  // Next state: DRAIN ends once the output slot is empty or emptying this cycle.
  always_comb begin
    // NOTE: the default assignment first means every path drives state_nx, so no latch.
    state_nx = state;
    unique case (state)
      IDLE:    if (ap_start) state_nx = RUN;
      RUN:     if (frame_end) state_nx = DRAIN;
      DRAIN:   if (!out_valid || out_ready) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  axis_reg_slice #(
    .WIDTH(PAY_W)
  ) u_out_reg (
    .clk      (ap_clk),
    .rst_n    (ap_rst_n),
    .load     (load),
    .in_data  (pay_in),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (pay_out)
  );

endmodule

// File: tb/tb_image_crop_stream.sv
// tb_image_crop_stream: self-checking bench for image_crop_stream. Three instances
// (default window, max-corner window, small frame) share one driver selected by sel.
// Honours CROP_TLAST_EN when defined.
module tb_image_crop_stream;

  localparam int W = 16;

  typedef struct packed {
    int rows; int cols; int orows; int ocols; int y1; int x1;
  } geom_t;

  logic          ap_clk = 1'b0;
  logic          rst_n;
  int            sel;
  logic          start_req;
  logic [W-1:0]  src_data;
  logic          src_valid, snk_ready, src_ready;
  logic          obs_valid, obs_done, obs_idle, obs_rdy;
  logic [W-1:0]  obs_data;
`ifdef CROP_TLAST_EN
  logic          obs_last;
`endif
  logic          start_d, done_d, idle_d, rdy_d;
  logic          start_c, done_c, idle_c, rdy_c;
  logic          start_s, done_s, idle_s, rdy_s;

  int            total = 0;
  int            bad   = 0;
  logic [W-1:0]  pix_mem [16000];

  always #5 ap_clk = ~ap_clk;

  image_crop_stream_if #(.WIDTH(W)) in_d ();
  image_crop_stream_if #(.WIDTH(W)) out_d ();
  image_crop_stream_if #(.WIDTH(W)) in_c ();
  image_crop_stream_if #(.WIDTH(W)) out_c ();
  image_crop_stream_if #(.WIDTH(W)) in_s ();
  image_crop_stream_if #(.WIDTH(W)) out_s ();

  image_crop_stream #(.FP_TOTAL(W)) dut_d (
    .ap_clk(ap_clk), .ap_rst_n(rst_n), .ap_start(start_d), .ap_done(done_d),
    .ap_idle(idle_d), .ap_ready(rdy_d), .img_in_V_data_0_V(in_d), .crop_out_V_data_0_V(out_d));

  image_crop_stream #(.FP_TOTAL(W), .Y_1(52), .X_1(112)) dut_c (
    .ap_clk(ap_clk), .ap_rst_n(rst_n), .ap_start(start_c), .ap_done(done_c),
    .ap_idle(idle_c), .ap_ready(rdy_c), .img_in_V_data_0_V(in_c), .crop_out_V_data_0_V(out_c));

  image_crop_stream #(.FP_TOTAL(W), .IN_ROWS(12), .IN_COLS(20), .OUT_ROWS(5), .OUT_COLS(6),
                      .Y_1(3), .X_1(4)) dut_s (
    .ap_clk(ap_clk), .ap_rst_n(rst_n), .ap_start(start_s), .ap_done(done_s),
    .ap_idle(idle_s), .ap_ready(rdy_s), .img_in_V_data_0_V(in_s), .crop_out_V_data_0_V(out_s));

  assign in_d.TDATA   = src_data;
  assign in_c.TDATA   = src_data;
  assign in_s.TDATA   = src_data;
  assign in_d.TVALID  = src_valid && (sel == 0);
  assign in_c.TVALID  = src_valid && (sel == 1);
  assign in_s.TVALID  = src_valid && (sel == 2);
  assign out_d.TREADY = snk_ready && (sel == 0);
  assign out_c.TREADY = snk_ready && (sel == 1);
  assign out_s.TREADY = snk_ready && (sel == 2);
  assign start_d      = start_req && (sel == 0);
  assign start_c      = start_req && (sel == 1);
  assign start_s      = start_req && (sel == 2);
`ifdef CROP_TLAST_EN
  assign in_d.TLAST   = 1'b0;
  assign in_c.TLAST   = 1'b0;
  assign in_s.TLAST   = 1'b0;
`endif

  // Route the selected instance's outputs to the observation signals.
  always_comb begin
    obs_valid = out_s.TVALID; obs_data = out_s.TDATA; src_ready = in_s.TREADY;
    obs_done  = done_s;       obs_idle = idle_s;      obs_rdy   = rdy_s;
`ifdef CROP_TLAST_EN
    obs_last  = out_s.TLAST;
`endif
    if (sel == 0) begin
      obs_valid = out_d.TVALID; obs_data = out_d.TDATA; src_ready = in_d.TREADY;
      obs_done  = done_d;       obs_idle = idle_d;      obs_rdy   = rdy_d;
`ifdef CROP_TLAST_EN
      obs_last  = out_d.TLAST;
`endif
    end else if (sel == 1) begin
      obs_valid = out_c.TVALID; obs_data = out_c.TDATA; src_ready = in_c.TREADY;
      obs_done  = done_c;       obs_idle = idle_c;      obs_rdy   = rdy_c;
`ifdef CROP_TLAST_EN
      obs_last  = out_c.TLAST;
`endif
    end
  end

  function automatic geom_t geom(input int s);
    geom_t g;
    case (s)
      0:       g = '{100, 160, 48, 48, 10, 10};
      1:       g = '{100, 160, 48, 48, 52, 112};
      default: g = '{12, 20, 5, 6, 3, 4};
    endcase
    return g;
  endfunction

  // Reference rule: a raster index is kept when its row and column fall inside the window.
  function automatic bit in_crop(input geom_t g, input int idx);
    int r = idx / g.cols;
    int c = idx % g.cols;
    return (r >= g.y1) && (r < g.y1 + g.orows) && (c >= g.x1) && (c < g.x1 + g.ocols);
  endfunction

  task automatic fill_pixels(input bit rnd);
    for (int i = 0; i < 16000; i++) pix_mem[i] = rnd ? W'($urandom) : W'(i);
  endtask

  // Streams one frame into the selected instance and scores every output beat against the
  // window of pix_mem. Optional 200-style sink stall, mid-frame reset and ap_start re-pulse.
  task automatic run_frame(input int s, input int vpct, input int rpct,
                           input int stall_px, input int stall_len, input int rst_px,
                           input bit pulse, output int beats, output int dones,
                           output int first_data, output int last_data);
    geom_t        g = geom(s);
    int           n = g.rows * g.cols;
    int           m = g.orows * g.ocols;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] prev_data = '0;
    int           in_idx = 0, cyc = 0, stall_left = 0, tail = 0;
    int           last_beat = -1, last_in = -1, done_cyc = -1, exp_done;
    int           limit = 4 * n + stall_len + 1000;
    bit           armed = (stall_px >= 0), stalled, prev_hold = 0, aborted = 0, exp_rdy;

    for (int i = 0; i < n; i++) if (in_crop(g, i)) exp_q.push_back(pix_mem[i]);
    beats = 0; dones = 0; first_data = -1; last_data = -1;
    sel = s;
    @(posedge ap_clk); #1 start_req = 1'b1;
    @(posedge ap_clk); #1 start_req = 1'b0;
    while (1) begin
      if (armed && in_idx >= stall_px) begin stall_left = stall_len; armed = 0; end
      stalled   = (stall_left > 0);
      src_valid = (in_idx < n) && ($urandom_range(99) < vpct);
      src_data  = (in_idx < n) ? pix_mem[in_idx] : '0;
      if (stalled) begin snk_ready = 1'b0; stall_left--; end
      else snk_ready = ($urandom_range(99) < rpct);
      start_req = pulse && (in_idx == n / 2);
      @(negedge ap_clk);
      if (rst_px >= 0 && in_idx >= rst_px) begin
        rst_n = 1'b0;
        #1;
        total++;
        if (obs_valid !== 1'b0 || obs_data !== '0 || src_ready !== 1'b0 || obs_idle !== 1'b1 ||
            obs_done !== 1'b0 || obs_rdy !== 1'b0)
          begin bad++; $display("FAIL midframe_reset: valid=%b data=%h in_ready=%b idle=%b done=%b ready=%b, required 0 0000 0 1 0 0",
                                obs_valid, obs_data, src_ready, obs_idle, obs_done, obs_rdy); end
        src_valid = 1'b0; snk_ready = 1'b0; start_req = 1'b0;
        @(posedge ap_clk); #1 rst_n = 1'b1;
        aborted = 1;
        break;
      end
      if (obs_done === 1'b1) begin
        dones++;
        if (dones == 1) done_cyc = cyc;
      end
      if (obs_valid === 1'b1 && snk_ready) begin
        total++;
        if (beats >= m) begin
          bad++; $display("FAIL extra_beat: beat %0d data=%h, required at most %0d beats", beats, obs_data, m);
        end else if (obs_data !== exp_q[beats]) begin
          bad++; $display("FAIL beat_data: beat %0d got %h, required %h", beats, obs_data, exp_q[beats]);
        end
`ifdef CROP_TLAST_EN
        total++;
        if (obs_last !== (beats == m - 1)) begin
          bad++; $display("FAIL tlast: beat %0d got %b, required %b", beats, obs_last, beats == m - 1);
        end
`endif
        if (beats == 0) first_data = int'(obs_data);
        last_data = int'(obs_data);
        beats++;
        last_beat = cyc;
      end
      if (stalled && obs_valid === 1'b1) begin
        exp_rdy = (in_idx < n) && !in_crop(g, in_idx);
        total++;
        if (src_ready !== exp_rdy) begin
          bad++; $display("FAIL stall_in_ready: px %0d got %b, required %b", in_idx, src_ready, exp_rdy);
        end
        if (prev_hold) begin
          total++;
          if (obs_data !== prev_data) begin
            bad++; $display("FAIL stall_hold: data got %h, required %h", obs_data, prev_data);
          end
        end
        prev_hold = 1; prev_data = obs_data;
      end else begin
        prev_hold = 0;
      end
      if (src_valid && src_ready === 1'b1) begin in_idx++; last_in = cyc; end
      if (dones > 0) tail++;
      if (tail > 4) break;
      if (cyc > limit) begin
        total++; bad++;
        $display("FAIL frame_timeout: px=%0d beats=%0d after %0d cycles, required frame end", in_idx, beats, cyc);
        aborted = 1;
        break;
      end
      cyc++;
      @(posedge ap_clk); #1;
    end
    start_req = 1'b0; src_valid = 1'b0;
    if (!aborted) begin
      exp_done = (last_beat + 1 > last_in + 2) ? last_beat + 1 : last_in + 2;
      total++;
      if (done_cyc != exp_done) begin
        bad++; $display("FAIL done_timing: ap_done at cycle %0d, required %0d", done_cyc, exp_done);
      end
      total++;
      if (obs_idle !== 1'b1) begin
        bad++; $display("FAIL idle_after_frame: got %b, required 1", obs_idle);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_req = 1'b0; src_valid = 1'b0; src_data = '0; snk_ready = 1'b0; sel = 0;
    repeat (3) @(posedge ap_clk);
    #1 rst_n = 1'b1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      @(negedge ap_clk);
      total++;
      if (obs_idle !== 1'b1) begin bad++; $display("FAIL reset_idle[%0d]: got %b, required 1", s, obs_idle); end
      total++;
      if (obs_done !== 1'b0 || obs_rdy !== 1'b0)
        begin bad++; $display("FAIL reset_done[%0d]: done=%b ready=%b, required 0 0", s, obs_done, obs_rdy); end
      total++;
      if (obs_valid !== 1'b0 || obs_data !== '0)
        begin bad++; $display("FAIL reset_out[%0d]: valid=%b data=%h, required 0 0000", s, obs_valid, obs_data); end
      total++;
      if (src_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready[%0d]: got %b, required 0", s, src_ready); end
`ifdef CROP_TLAST_EN
      total++;
      if (obs_last !== 1'b0) begin bad++; $display("FAIL reset_tlast[%0d]: got %b, required 0", s, obs_last); end
`endif
    end
  endtask

  task automatic test_full_rate();
    int beats, dones, first, last;
    fill_pixels(0);
    run_frame(0, 100, 100, -1, 0, -1, 0, beats, dones, first, last);
    total++; if (beats != 2304) begin bad++; $display("FAIL full_beats: got %0d, required 2304", beats); end
    total++; if (first != 1610) begin bad++; $display("FAIL full_first: got %0d, required 1610", first); end
    total++; if (last != 9177)  begin bad++; $display("FAIL full_last: got %0d, required 9177", last); end
    total++; if (dones != 1)    begin bad++; $display("FAIL full_dones: got %0d, required 1", dones); end
  endtask

  task automatic test_stall_then_reset();
    int beats, dones, first, last, exp_beats = 0;
    geom_t g = geom(0);
    fill_pixels(0);
    for (int i = 0; i < 5000 - 1; i++) if (in_crop(g, i)) exp_beats++;
    run_frame(0, 100, 100, 20 * 160 + 58, 200, 5000, 0, beats, dones, first, last);
    total++; if (beats != exp_beats) begin bad++; $display("FAIL stall_beats: got %0d, required %0d", beats, exp_beats); end
    total++; if (dones != 0) begin bad++; $display("FAIL reset_no_done: got %0d, required 0", dones); end
  endtask

  task automatic test_restart();
    int beats, dones, first, last;
    fill_pixels(1);
    run_frame(0, 100, 60, -1, 0, -1, 0, beats, dones, first, last);
    total++; if (beats != 2304) begin bad++; $display("FAIL restart_beats: got %0d, required 2304", beats); end
    total++; if (first != int'(pix_mem[10 * 160 + 10]))
      begin bad++; $display("FAIL restart_first: got %0h, required %0h", first, pix_mem[10 * 160 + 10]); end
    total++; if (dones != 1) begin bad++; $display("FAIL restart_dones: got %0d, required 1", dones); end
  endtask

  task automatic test_back_to_back();
    int beats, dones, first, last;
    for (int f = 0; f < 3; f++) begin
      fill_pixels(1);
      run_frame(2, 50, 50, -1, 0, -1, 0, beats, dones, first, last);
      total++; if (beats != 30) begin bad++; $display("FAIL b2b_beats[%0d]: got %0d, required 30", f, beats); end
      total++; if (dones != 1)  begin bad++; $display("FAIL b2b_dones[%0d]: got %0d, required 1", f, dones); end
    end
  endtask

  task automatic test_start_ignored();
    int beats, dones, first, last;
    fill_pixels(1);
    run_frame(2, 100, 100, -1, 0, -1, 1, beats, dones, first, last);
    total++; if (dones != 1)  begin bad++; $display("FAIL restart_pulse_dones: got %0d, required 1", dones); end
    total++; if (beats != 30) begin bad++; $display("FAIL restart_pulse_beats: got %0d, required 30", beats); end
  endtask

  task automatic test_max_corner();
    int beats, dones, first, last;
    fill_pixels(0);
    run_frame(1, 100, 100, -1, 0, -1, 0, beats, dones, first, last);
    total++; if (beats != 2304)  begin bad++; $display("FAIL corner_beats: got %0d, required 2304", beats); end
    total++; if (first != 8432)  begin bad++; $display("FAIL corner_first: got %0d, required 8432", first); end
    total++; if (last != 15999)  begin bad++; $display("FAIL corner_last: got %0d, required 15999", last); end
    total++; if (dones != 1)     begin bad++; $display("FAIL corner_dones: got %0d, required 1", dones); end
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_stall_then_reset();
    test_restart();
    test_back_to_back();
    test_start_ignored();
    test_max_corner();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
